wb_regfile: RTL

- Consumer end of the writeback interface: an 8-entry x 8-bit register file whose write port is fed by the writeback mux output AorD.
- Two combinational read ports supply the decode stage.
- A per-register pending scoreboard tracks writes that have been issued but not yet written back. Decode uses it to detect read-after-write hazards and stall.
- Sits between the WB stage (write side) and the ID stage (read and issue side).

---
 rtl/wb_regfile_if.sv | 37 +++
 rtl/wb_regfile.sv | 101 ++++++++++
 2 files changed

// File: rtl/wb_regfile_if.sv
// wb_regfile_if
//   Bundles the writeback, issue and decode-read signals exchanged between the
//   WB/ID stages and the register file.
//   Write side : AorD (data), WBAD (dest reg), WBEN (writeback strobe)
//   Issue side : ISSUE (instruction issued), ISAD (its destination register)
//   Read side  : RA1/RA2 (addresses) -> RD1/RD2 (data), BUSY1/BUSY2 (pending),
//                STALL (either read operand pending), PCNT (pending count)
//   The master modport is the pipeline side; the slave modport is the
//   register file.
interface wb_regfile_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic [DW-1:0] AorD;
  logic [AW-1:0] WBAD;
  logic          WBEN;
  logic          ISSUE;
  logic [AW-1:0] ISAD;
  logic [AW-1:0] RA1;
  logic [AW-1:0] RA2;
  logic [DW-1:0] RD1;
  logic [DW-1:0] RD2;
  logic          BUSY1;
  logic          BUSY2;
  logic          STALL;
  logic [AW:0]   PCNT;

  modport master (
    output AorD, WBAD, WBEN, ISSUE, ISAD, RA1, RA2,
    input  RD1, RD2, BUSY1, BUSY2, STALL, PCNT
  );

  modport slave (
    input  AorD, WBAD, WBEN, ISSUE, ISAD, RA1, RA2,
    output RD1, RD2, BUSY1, BUSY2, STALL, PCNT
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile
//   8 x 8-bit register file with a per-register pending scoreboard. The write
//   port takes the writeback mux output; two combinational read ports feed
//   decode together with busy flags used for read-after-write stall detection.
//   Ports:
//     clk  - rising-edge clock for all state
//     rst  - synchronous active-high reset (clears registers and scoreboard)
//     bus  - wb_regfile_if.slave: AorD/WBAD/WBEN write, ISSUE/ISAD scoreboard
//            set, RA1/RA2 -> RD1/RD2/BUSY1/BUSY2/STALL, PCNT pending count
//   Optional feature macro: WB_BYPASS_EN
//     When defined, a writeback in flight is forwarded combinationally to any
//     read port addressing the same register, and that port's busy flag is
//     dropped unless the same cycle also issues a new producer for it.
module wb_regfile #(
  parameter int DW   = 8,
  parameter int AW   = 3,
  parameter int NREG = 8
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic [AW:0]     pcnt_q;
  logic [AW:0]     pcnt_d;

  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          busy1;
  logic          busy2;

  // Next-state: the clear from writeback is applied before the set from issue
  // so a same-register collision leaves the bit set (a newer producer is
  // outstanding). The count is taken from the next pending vector so PCNT
  // moves on the same edge as the bits themselves.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    pcnt_d = '0;
    if (bus.WBEN) begin
      regs_d[bus.WBAD] = bus.AorD;
      pend_d[bus.WBAD] = 1'b0;
    end
    if (bus.ISSUE) begin
      pend_d[bus.ISAD] = 1'b1;
    end
    for (int i = 0; i < NREG; i++) begin
      pcnt_d = pcnt_d + {{AW{1'b0}}, pend_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
      pcnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      pcnt_q <= pcnt_d;
    end
  end

  // Read ports and busy flags come straight from stored state; the bypass
  // build overlays an in-flight writeback on top of that.
  always_comb begin
    rd1   = regs_q[bus.RA1];
    rd2   = regs_q[bus.RA2];
    busy1 = pend_q[bus.RA1];
    busy2 = pend_q[bus.RA2];
`ifdef WB_BYPASS_EN
    if (bus.WBEN && (bus.WBAD == bus.RA1)) begin
      rd1 = bus.AorD;
      if (!(bus.ISSUE && (bus.ISAD == bus.RA1))) begin
        busy1 = 1'b0;
      end
    end
    if (bus.WBEN && (bus.WBAD == bus.RA2)) begin
      rd2 = bus.AorD;
      if (!(bus.ISSUE && (bus.ISAD == bus.RA2))) begin
        busy2 = 1'b0;
      end
    end
`else
`endif
  end

  assign bus.RD1   = rd1;
  assign bus.RD2   = rd2;
  assign bus.BUSY1 = busy1;
  assign bus.BUSY2 = busy2;
  assign bus.STALL = busy1 | busy2;
  assign bus.PCNT  = pcnt_q;

endmodule
